// File: rtl/pc_seq_pkg.sv
// Shared types for the program-counter sequencer: FSM states, next-PC selects
// and the default boot address.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        HALT
    } seq_state_t;

    typedef enum logic [2:0] {
        SEL_PC4,
        SEL_BR,
        SEL_JR,
        SEL_J,
        SEL_HOLD
    } pc_sel_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/pc_target_calc.sv
// Purely combinational branch and jump target generation. All arithmetic
// wraps modulo 2^32.
module pc_target_calc (
    input  logic [31:0] branch_pc4,
    input  logic [31:0] branch_offset,
    input  logic [31:0] jump_pc4,
    input  logic [25:0] jump_index,
    output logic [31:0] br_tgt,
    output logic [31:0] j_tgt
);

    // Only the region bits of the jump PC+4 select the 256 MB segment.
    logic unused_jump_bits;

    assign br_tgt           = branch_pc4 + (branch_offset << 2);
    assign j_tgt            = {jump_pc4[31:28], jump_index, 2'b00};
    assign unused_jump_bits = ^jump_pc4[27:0];

endmodule

// File: rtl/pc_sequencer.sv
// Program counter owner for the pipelined MIPS core: boot/run/halt sequencing,
// redirect priority (branch > jr > jump > stall > PC+4) and a redirect counter.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             halt_req,
    input  logic             branch_req,
    input  logic             branch_cond,
    input  logic [31:0]      branch_pc4,
    input  logic [31:0]      branch_offset,
    input  logic             jump_req,
    input  logic [31:0]      jump_pc4,
    input  logic [25:0]      jump_index,
    input  logic             jr_req,
    input  logic [31:0]      jr_addr,
    output logic [31:0]      pc,
    output logic [31:0]      pc_plus4,
    output logic             fetch_en,
    output logic             flush_if,
    output logic             flush_id,
    output logic [CNT_W-1:0] redirect_count
);

    seq_state_t state;
    pc_sel_t    sel;
    logic [31:0] br_tgt;
    logic [31:0] j_tgt;
    logic [31:0] next_pc;
    logic        branch_taken;
    logic        redirect;
    logic        in_run;

    pc_target_calc u_target (
        .branch_pc4    (branch_pc4),
        .branch_offset (branch_offset),
        .jump_pc4      (jump_pc4),
        .jump_index    (jump_index),
        .br_tgt        (br_tgt),
        .j_tgt         (j_tgt)
    );

    assign pc_plus4     = pc + 32'd4;
    assign branch_taken = branch_req & branch_cond;
    assign in_run       = (state == RUN);

    // The oldest instruction in the pipe wins; a taken branch in EX also
    // kills whatever jump/jr sits behind it in ID.
    always_comb begin
        sel = SEL_PC4;
        if (branch_taken)
            sel = SEL_BR;
        else if (jr_req)
            sel = SEL_JR;
        else if (jump_req)
            sel = SEL_J;
        else if (stall)
            sel = SEL_HOLD;
    end

    always_comb begin
        next_pc = pc_plus4;
        case (sel)
            SEL_BR:   next_pc = br_tgt;
            SEL_JR:   next_pc = jr_addr;
            SEL_J:    next_pc = j_tgt;
            SEL_HOLD: next_pc = pc;
            default:  next_pc = pc_plus4;
        endcase
    end

    assign redirect = (sel == SEL_BR) || (sel == SEL_JR) || (sel == SEL_J);
    assign fetch_en = in_run & ~stall;
    assign flush_if = in_run & redirect;
    assign flush_id = in_run & (sel == SEL_BR);

    // A halt request is deferred while a redirect is pending so the
    // redirect lands first; the halt edge itself freezes the PC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= BOOT;
            pc             <= RESET_PC;
            redirect_count <= '0;
        end else begin
            case (state)
                BOOT: begin
                    state <= RUN;
                    pc    <= RESET_PC;
                end
                RUN: begin
                    if (halt_req && !redirect)
                        state <= HALT;
                    else
                        pc <= next_pc;
                    if (redirect && (redirect_count != {CNT_W{1'b1}}))
                        redirect_count <= redirect_count + CNT_W'(1);
                end
                HALT: state <= HALT;
                default: state <= BOOT;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: an independent next-PC model queues
// expected outputs per cycle, each scenario task pops and compares them.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, halt_req, branch_req, branch_cond, jump_req, jr_req;
    logic [31:0] branch_pc4, branch_offset, jump_pc4, jr_addr;
    logic [25:0] jump_index;
    logic [31:0] pc, pc_plus4;
    logic        fetch_en, flush_if, flush_id;
    logic [15:0] redirect_count;

    typedef struct {
        logic        stall, halt, breq, bcond, jreq, jrreq;
        logic [31:0] bpc4, boff, jpc4, jraddr;
        logic [25:0] jidx;
    } stim_t;

    typedef struct {
        logic [31:0] exp_pc, obs_pc;
        logic [15:0] exp_cnt, obs_cnt;
        logic        exp_fe, obs_fe, exp_fi, obs_fi, exp_fd, obs_fd;
    } rec_t;

    rec_t sbq[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model state: 0 = boot, 1 = run, 2 = halt.
    int          mState;
    logic [31:0] mPc;
    logic [15:0] mCnt;

    pc_sequencer dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .halt_req       (halt_req),
        .branch_req     (branch_req),
        .branch_cond    (branch_cond),
        .branch_pc4     (branch_pc4),
        .branch_offset  (branch_offset),
        .jump_req       (jump_req),
        .jump_pc4       (jump_pc4),
        .jump_index     (jump_index),
        .jr_req         (jr_req),
        .jr_addr        (jr_addr),
        .pc             (pc),
        .pc_plus4       (pc_plus4),
        .fetch_en       (fetch_en),
        .flush_if       (flush_if),
        .flush_id       (flush_id),
        .redirect_count (redirect_count)
    );

    always #5 clk = ~clk;

    function automatic stim_t idle();
        stim_t s;
        s.stall = 0; s.halt = 0; s.breq = 0; s.bcond = 0; s.jreq = 0; s.jrreq = 0;
        s.bpc4 = 0; s.boff = 0; s.jpc4 = 0; s.jraddr = 0; s.jidx = 0;
        return s;
    endfunction

    function automatic stim_t mkBranch(logic [31:0] pc4, logic [31:0] off, logic cond);
        stim_t s = idle();
        s.breq = 1; s.bcond = cond; s.bpc4 = pc4; s.boff = off;
        return s;
    endfunction

    function automatic stim_t mkJump(logic [31:0] pc4, logic [25:0] idx);
        stim_t s = idle();
        s.jreq = 1; s.jpc4 = pc4; s.jidx = idx;
        return s;
    endfunction

    function automatic stim_t mkJr(logic [31:0] addr);
        stim_t s = idle();
        s.jrreq = 1; s.jraddr = addr;
        return s;
    endfunction

    task automatic modelReset();
        mState = 0;
        mPc    = 32'h0;
        mCnt   = 16'h0;
    endtask

    // Drive one cycle of stimulus (called at posedge+1), sample combinational
    // outputs at the negedge and registered outputs just after the next posedge.
    task automatic applyStimulus(input stim_t s);
        rec_t        r;
        logic        taken, redir;
        logic [31:0] brt, jt;
        stall = s.stall; halt_req = s.halt; branch_req = s.breq; branch_cond = s.bcond;
        branch_pc4 = s.bpc4; branch_offset = s.boff; jump_req = s.jreq;
        jump_pc4 = s.jpc4; jump_index = s.jidx; jr_req = s.jrreq; jr_addr = s.jraddr;
        taken    = s.breq && s.bcond;
        redir    = (mState == 1) && (taken || s.jrreq || s.jreq);
        brt      = s.bpc4 + s.boff * 32'd4;
        jt       = {s.jpc4[31:28], s.jidx, 2'b00};
        r.exp_fe = (mState == 1) && !s.stall;
        r.exp_fi = redir;
        r.exp_fd = (mState == 1) && taken;
        @(negedge clk);
        r.obs_fe = fetch_en; r.obs_fi = flush_if; r.obs_fd = flush_id;
        @(posedge clk);
        if (mState == 0) begin
            mState = 1;
        end else if (mState == 1) begin
            if (taken)            mPc = brt;
            else if (s.jrreq)     mPc = s.jraddr;
            else if (s.jreq)      mPc = jt;
            else if (s.halt)      mState = 2;
            else if (!s.stall)    mPc = mPc + 32'd4;
            if (redir && mCnt != 16'hFFFF) mCnt = mCnt + 16'd1;
        end
        r.exp_pc = mPc; r.exp_cnt = mCnt;
        #1;
        r.obs_pc = pc; r.obs_cnt = redirect_count;
        sbq.push_back(r);
    endtask

    task automatic test_reset();
        rst_n = 0;
        applyStimulus(idle());
        sbq.delete();
        modelReset();
        checks += 4;
        if (pc !== 32'h0) begin errors++; $display("[TB] FAIL reset_pc got=%h exp=%h", pc, 32'h0); end
        if (fetch_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_fetch got=%b exp=0", fetch_en); end
        if ({flush_if, flush_id} !== 2'b00) begin errors++; $display("[TB] FAIL reset_flush got=%b%b exp=00", flush_if, flush_id); end
        if (redirect_count !== 16'h0) begin errors++; $display("[TB] FAIL reset_count got=%h exp=0", redirect_count); end
        rst_n = 1;
    endtask

    task automatic test_boot_sequence();
        rec_t r;
        for (int i = 0; i < 4; i++) applyStimulus(idle());
        while (sbq.size() > 0) begin
            r = sbq.pop_front();
            checks += 5;
            if (r.obs_pc  !== r.exp_pc)  begin errors++; $display("[TB] FAIL boot_pc got=%h exp=%h", r.obs_pc, r.exp_pc); end
            if (r.obs_cnt !== r.exp_cnt) begin errors++; $display("[TB] FAIL boot_cnt got=%h exp=%h", r.obs_cnt, r.exp_cnt); end
            if (r.obs_fe  !== r.exp_fe)  begin errors++; $display("[TB] FAIL boot_fetch got=%b exp=%b", r.obs_fe, r.exp_fe); end
            if (r.obs_fi  !== r.exp_fi)  begin errors++; $display("[TB] FAIL boot_flush_if got=%b exp=%b", r.obs_fi, r.exp_fi); end
            if (r.obs_fd  !== r.exp_fd)  begin errors++; $display("[TB] FAIL boot_flush_id got=%b exp=%b", r.obs_fd, r.exp_fd); end
        end
    endtask

    task automatic test_redirects();
        rec_t  r;
        stim_t s;
        applyStimulus(mkBranch(32'h0000_0100, 32'hFFFF_FFFE, 1'b1));
        applyStimulus(mkBranch(32'h0000_0200, 32'h0000_0010, 1'b0));
        applyStimulus(mkJump(32'h4000_0010, 26'h000_0040));
        applyStimulus(mkJr(32'h1234_5678));
        s = mkBranch(32'h0000_1000, 32'h0000_0004, 1'b1);
        s.jreq = 1; s.jpc4 = 32'h8000_0000; s.jidx = 26'h3FF_FFFF; s.stall = 1;
        applyStimulus(s);
        s = mkJr(32'hABCD_0000);
        s.jreq = 1; s.jpc4 = 32'h4000_0000; s.jidx = 26'h000_0001;
        applyStimulus(s);
        s = mkJump(32'h7000_0000, 26'h012_3456);
        s.stall = 1;
        applyStimulus(s);
        applyStimulus(mkJr(32'hFFFF_FFFC));
        applyStimulus(idle());
        while (sbq.size() > 0) begin
            r = sbq.pop_front();
            checks += 5;
            if (r.obs_pc  !== r.exp_pc)  begin errors++; $display("[TB] FAIL redirect_pc got=%h exp=%h", r.obs_pc, r.exp_pc); end
            if (r.obs_cnt !== r.exp_cnt) begin errors++; $display("[TB] FAIL redirect_cnt got=%h exp=%h", r.obs_cnt, r.exp_cnt); end
            if (r.obs_fe  !== r.exp_fe)  begin errors++; $display("[TB] FAIL redirect_fetch got=%b exp=%b", r.obs_fe, r.exp_fe); end
            if (r.obs_fi  !== r.exp_fi)  begin errors++; $display("[TB] FAIL redirect_flush_if got=%b exp=%b", r.obs_fi, r.exp_fi); end
            if (r.obs_fd  !== r.exp_fd)  begin errors++; $display("[TB] FAIL redirect_flush_id got=%b exp=%b", r.obs_fd, r.exp_fd); end
        end
    endtask

    task automatic test_stall();
        rec_t  r;
        stim_t s;
        applyStimulus(mkJr(32'h0000_0020));
        s = idle(); s.stall = 1;
        for (int i = 0; i < 3; i++) applyStimulus(s);
        applyStimulus(idle());
        applyStimulus(idle());
        while (sbq.size() > 0) begin
            r = sbq.pop_front();
            checks += 5;
            if (r.obs_pc  !== r.exp_pc)  begin errors++; $display("[TB] FAIL stall_pc got=%h exp=%h", r.obs_pc, r.exp_pc); end
            if (r.obs_cnt !== r.exp_cnt) begin errors++; $display("[TB] FAIL stall_cnt got=%h exp=%h", r.obs_cnt, r.exp_cnt); end
            if (r.obs_fe  !== r.exp_fe)  begin errors++; $display("[TB] FAIL stall_fetch got=%b exp=%b", r.obs_fe, r.exp_fe); end
            if (r.obs_fi  !== r.exp_fi)  begin errors++; $display("[TB] FAIL stall_flush_if got=%b exp=%b", r.obs_fi, r.exp_fi); end
            if (r.obs_fd  !== r.exp_fd)  begin errors++; $display("[TB] FAIL stall_flush_id got=%b exp=%b", r.obs_fd, r.exp_fd); end
        end
    endtask

    task automatic test_saturate();
        rec_t r;
        for (int i = 0; i < 65540; i++) begin
            applyStimulus(mkJr({$urandom_range(0, 32'h3FFF_FFFF), 2'b00}));
            r = sbq.pop_front();
            checks += 2;
            if (r.obs_pc  !== r.exp_pc)  begin errors++; $display("[TB] FAIL saturate_pc got=%h exp=%h", r.obs_pc, r.exp_pc); end
            if (r.obs_cnt !== r.exp_cnt) begin errors++; $display("[TB] FAIL saturate_cnt got=%h exp=%h", r.obs_cnt, r.exp_cnt); end
        end
        checks++;
        if (redirect_count !== 16'hFFFF) begin errors++; $display("[TB] FAIL saturate_final got=%h exp=ffff", redirect_count); end
    endtask

    task automatic test_halt_reset();
        rec_t  r;
        stim_t s;
        applyStimulus(idle());
        s = mkJump(32'h5000_0000, 26'h000_0100);
        s.halt = 1;
        applyStimulus(s);
        s = idle(); s.halt = 1;
        applyStimulus(s);
        s = mkBranch(32'h0000_0400, 32'h0000_0008, 1'b1);
        s.jreq = 1; s.jidx = 26'h000_0FFF;
        for (int i = 0; i < 3; i++) applyStimulus(s);
        while (sbq.size() > 0) begin
            r = sbq.pop_front();
            checks += 5;
            if (r.obs_pc  !== r.exp_pc)  begin errors++; $display("[TB] FAIL halt_pc got=%h exp=%h", r.obs_pc, r.exp_pc); end
            if (r.obs_cnt !== r.exp_cnt) begin errors++; $display("[TB] FAIL halt_cnt got=%h exp=%h", r.obs_cnt, r.exp_cnt); end
            if (r.obs_fe  !== r.exp_fe)  begin errors++; $display("[TB] FAIL halt_fetch got=%b exp=%b", r.obs_fe, r.exp_fe); end
            if (r.obs_fi  !== r.exp_fi)  begin errors++; $display("[TB] FAIL halt_flush_if got=%b exp=%b", r.obs_fi, r.exp_fi); end
            if (r.obs_fd  !== r.exp_fd)  begin errors++; $display("[TB] FAIL halt_flush_id got=%b exp=%b", r.obs_fd, r.exp_fd); end
        end
        // Asynchronous reset in the middle of a cycle while halted.
        #2;
        rst_n = 0;
        #1;
        modelReset();
        checks += 3;
        if (pc !== 32'h0) begin errors++; $display("[TB] FAIL midreset_pc got=%h exp=%h", pc, 32'h0); end
        if (fetch_en !== 1'b0) begin errors++; $display("[TB] FAIL midreset_fetch got=%b exp=0", fetch_en); end
        if (redirect_count !== 16'h0) begin errors++; $display("[TB] FAIL midreset_count got=%h exp=0", redirect_count); end
        @(posedge clk);
        #1;
        rst_n = 1;
        for (int i = 0; i < 3; i++) applyStimulus(idle());
        while (sbq.size() > 0) begin
            r = sbq.pop_front();
            checks += 2;
            if (r.obs_pc !== r.exp_pc) begin errors++; $display("[TB] FAIL reboot_pc got=%h exp=%h", r.obs_pc, r.exp_pc); end
            if (r.obs_fe !== r.exp_fe) begin errors++; $display("[TB] FAIL reboot_fetch got=%b exp=%b", r.obs_fe, r.exp_fe); end
        end
    endtask

    initial begin
        rst_n = 0;
        modelReset();
        stall = 0; halt_req = 0; branch_req = 0; branch_cond = 0; jump_req = 0; jr_req = 0;
        branch_pc4 = 0; branch_offset = 0; jump_pc4 = 0; jump_index = 0; jr_addr = 0;
        @(posedge clk);
        #1;
        test_reset();
        test_boot_sequence();
        test_redirects();
        test_stall();
        test_saturate();
        test_halt_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
